ram_led_streamer: RTL and testbench
===================================

// Module: ram_led_streamer
// PURPOSE
//  Fabric-side reader of the HPS-shared on-chip RAM (ram_* slave of soc_system, 8-bit data, 13-bit address).
//  On a start pulse it fetches NUM_LEDS*3 colour bytes and serialises them to a WS2812 LED strip on led_dout.
//  Byte fetches are prefetched, so the bit stream has no gaps; a latch/reset period follows each frame.
//  Sits between soc_system ram_* ports and the ambilight LED output pin, all in the clk_clk domain.
// PARAMETERS
//  ADDR_W      13    RAM address width
//  BASE_ADDR   0     byte address of first colour byte
//  NUM_LEDS    60    LEDs per frame; frame = 3*NUM_LEDS bytes, wire order G,R,B per LED
//  RD_LATENCY  1     cycles from address/chipselect to valid ram_readdata (1 or 2)
//  T0H         20    high cycles for a '0' bit (0.4 us @ 50 MHz)
//  T1H         40    high cycles for a '1' bit (0.8 us @ 50 MHz)
//  TBIT        63    total cycles per bit (1.26 us @ 50 MHz); requires T0H < T1H < TBIT
//  TLATCH      3000  low cycles after last bit (60 us @ 50 MHz)
// PORTS
//  clk_clk         in   1       system clock (same clock as ram_clk_clk)
//  reset_reset_n   in   1       asynchronous active-low reset
//  start           in   1       1-cycle pulse: begin a frame
//  ram_address     out  ADDR_W  byte address to RAM
//  ram_chipselect  out  1       read strobe, one cycle per byte
//  ram_clken       out  1       RAM clock enable, constant 1 out of reset
//  ram_write       out  1       constant 0 (read-only master)
//  ram_writedata   out  8       constant 0
//  ram_readdata    in   8       RAM read data
//  led_dout        out  1       WS2812 serial data
//  busy            out  1       high from frame accept until latch period ends
//  frame_done      out  1       1-cycle pulse on last cycle of latch period
// BEHAVIOUR
//  Reset (async assert): ram_address=BASE_ADDR, ram_chipselect=0, ram_clken=1, ram_write=0,
//   ram_writedata=0, led_dout=0, busy=0, frame_done=0, FSM=IDLE; all counters cleared.
//  Reset mid-frame aborts immediately: led_dout low same instant, no partial resume after release.
//  FSM: IDLE -> PREFETCH -> SEND -> LATCH -> IDLE.
//  IDLE: start=1 -> PREFETCH, busy=1 next cycle. start while busy=1 is ignored (not queued).
//  PREFETCH: chipselect=1 for one cycle with ram_address=BASE_ADDR; data captured RD_LATENCY cycles later
//   into shift register; next cycle -> SEND (startup latency start->first led_dout rise = RD_LATENCY+2).
//  SEND: bits MSB first; each bit = TBIT cycles; led_dout=1 for first T1H (bit=1) or T0H (bit=0) cycles, else 0.
//   At cycle 0 of bit 7 (MSB) of byte k, if k+1 < 3*NUM_LEDS: chipselect=1 one cycle, address=BASE_ADDR+k+1;
//   readdata captured to next_byte after RD_LATENCY cycles. After bit 0 (LSB) period, next_byte loads shift
//   register with zero idle cycles between bytes. After LSB of byte 3*NUM_LEDS-1 -> LATCH.
//  LATCH: led_dout=0 for exactly TLATCH cycles; frame_done=1 on the final cycle; busy drops the cycle after.
//  Address arithmetic: address = BASE_ADDR + byte index, ADDR_W bits, truncating wrap at 2^ADDR_W;
//   BASE_ADDR+3*NUM_LEDS > 2^ADDR_W is an elaboration error.
//  ram_address holds last issued value when chipselect=0. Exactly 3*NUM_LEDS reads per frame, none outside SEND/PREFETCH.
//  Frame length: RD_LATENCY+1 + 24*NUM_LEDS*TBIT + TLATCH cycles from start accept to busy fall.
//  RAM contents changing mid-frame (HPS writes): bytes already fetched are sent unchanged; no coherency.
// TESTING
//  1. NUM_LEDS=1, RAM[0..2]=8'hFF,8'h00,8'hA5, start -> led_dout highs: 8x40, 8x20, then 40,20,40,20,20,40,20,40
//     cycles; each bit period 63; then 3000 low; frame_done once; busy low after.
//  2. NUM_LEDS=2, BASE_ADDR=16 -> exactly 6 chipselect pulses at addresses 16..21, each issued at MSB start
//     of preceding byte; no gap between consecutive bit periods (period measured = 63 everywhere).
//  3. RD_LATENCY=2 with model RAM of latency 2, RAM=8'h80,.. -> first rising edge at start+4, data bit-exact.
//  4. start pulsed again mid-SEND and during LATCH -> ignored; exactly one frame_done; read count unchanged.
//  5. reset_reset_n low while led_dout high mid-byte 1 -> led_dout=0 and busy=0 immediately; after release
//     no activity until new start, next frame restarts at BASE_ADDR.
//  6. Back-to-back: start issued the cycle after frame_done -> accepted, new frame identical to previous.

Source files
------------

// File: rtl/ram_led_streamer_if.sv
// rtl/ram_led_streamer_if.sv - byte-wide read port between the LED streamer and the shared on-chip RAM
//
// Purpose: groups the ram_* signals of the soc_system on-chip RAM slave.
// Ports (signals):
//   ram_address     master->slave  ADDR_W  byte address
//   ram_chipselect  master->slave  1       read strobe
//   ram_clken       master->slave  1       RAM clock enable
//   ram_write       master->slave  1       write strobe (unused by a read-only master)
//   ram_writedata   master->slave  8       write data
//   ram_readdata    slave->master  8       read data
interface ram_led_streamer_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_clken;
  logic              ram_write;
  logic [7:0]        ram_writedata;
  logic [7:0]        ram_readdata;

  modport master (
    output ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata,
    input  ram_readdata
  );

  modport slave (
    input  ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata,
    output ram_readdata
  );
endinterface

// File: rtl/ram_led_streamer.sv
// rtl/ram_led_streamer.sv - WS2812 frame streamer fed from the HPS-shared on-chip RAM
//
// Purpose: on a start pulse, reads 3*NUM_LEDS colour bytes (G,R,B per LED) from RAM
// starting at BASE_ADDR and serialises them MSB first on led_dout, followed by a
// TLATCH-cycle low latch period. The next byte is fetched while the current byte is
// shifting out, so consecutive bit periods are back to back.
// Ports:
//   clk_clk        in   system clock (shared with the RAM)
//   reset_reset_n  in   asynchronous active-low reset
//   start          in   1-cycle frame request, ignored while busy
//   ram            if   master side of the RAM read port
//   led_dout       out  WS2812 serial data
//   busy           out  high from frame accept until the latch period ends
//   frame_done     out  1-cycle pulse on the last latch cycle
module ram_led_streamer #(
  parameter int ADDR_W     = 13,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_LEDS   = 60,
  parameter int RD_LATENCY = 1,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int TBIT       = 63,
  parameter int TLATCH     = 3000
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  ram_led_streamer_if.master ram,
  output logic               led_dout,
  output logic               busy,
  output logic               frame_done
);

  localparam int NBYTES = 3 * NUM_LEDS;
  localparam int CMAX   = (TLATCH > TBIT) ? TLATCH : TBIT;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int BW     = $clog2(NBYTES + 1);

  localparam logic [CW-1:0]     TBIT_END   = CW'(TBIT - 1);
  localparam logic [CW-1:0]     TLATCH_END = CW'(TLATCH - 1);
  localparam logic [CW-1:0]     T0H_C      = CW'(T0H);
  localparam logic [CW-1:0]     T1H_C      = CW'(T1H);
  localparam logic [CW-1:0]     RDL_C      = CW'(RD_LATENCY);
  localparam logic [BW-1:0]     LAST_BYTE  = BW'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(BASE_ADDR);

  if (BASE_ADDR + NBYTES > (2 ** ADDR_W)) begin : g_bad_addr
    $error("ram_led_streamer: frame does not fit in the RAM address space");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 2 || !(T0H < T1H && T1H < TBIT) || TBIT <= RD_LATENCY) begin : g_bad_timing
    $error("ram_led_streamer: illegal timing parameters");
  end

  typedef enum logic [1:0] {IDLE, PREFETCH, SEND, LATCH} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cyc;        // cycle within PREFETCH, bit period or latch
  logic [2:0]          bit_idx;    // bit being sent, 7 = MSB
  logic [BW-1:0]       byte_idx;   // byte being sent
  logic [7:0]          shift_q;    // current byte, bit 7 is on the wire
  logic [7:0]          next_byte;  // prefetched following byte
  logic [ADDR_W-1:0]   addr_q;     // last issued address
  logic                rd_issue;
  logic [ADDR_W-1:0]   rd_addr;
  logic                last_byte;
  logic                bit_end;
  logic                fetch_slot;

  assign last_byte  = (byte_idx == LAST_BYTE);
  assign bit_end    = (cyc == TBIT_END);
  // Next byte is requested at the start of the MSB of the current byte and
  // captured RD_LATENCY cycles later, well before the LSB ends.
  assign fetch_slot = (bit_idx == 3'd7) && !last_byte;

  assign ram.ram_chipselect = rd_issue;
  assign ram.ram_address    = rd_issue ? rd_addr : addr_q;
  assign ram.ram_clken      = 1'b1;
  assign ram.ram_write      = 1'b0;
  assign ram.ram_writedata  = 8'h00;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rd_issue   = 1'b0;
    rd_addr    = BASE_C + ADDR_W'(byte_idx) + ADDR_W'(1);
    led_dout   = 1'b0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = PREFETCH;
      end
      PREFETCH: begin
        rd_issue = (cyc == '0);
        rd_addr  = BASE_C;
        if (cyc == RDL_C) state_nxt = SEND;
      end
      SEND: begin
        rd_issue = fetch_slot && (cyc == '0);
        led_dout = shift_q[7] ? (cyc < T1H_C) : (cyc < T0H_C);
        if (bit_end && bit_idx == 3'd0 && last_byte) state_nxt = LATCH;
      end
      LATCH: begin
        if (cyc == TLATCH_END) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cyc       <= '0;
      bit_idx   <= 3'd7;
      byte_idx  <= '0;
      shift_q   <= 8'h00;
      next_byte <= 8'h00;
      addr_q    <= BASE_C;
    end else begin
      if (rd_issue) addr_q <= rd_addr;
      case (state)
        IDLE: begin
          cyc      <= '0;
          bit_idx  <= 3'd7;
          byte_idx <= '0;
        end
        PREFETCH: begin
          if (cyc == RDL_C) begin
            shift_q <= ram.ram_readdata;
            cyc     <= '0;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        SEND: begin
          if (fetch_slot && cyc == RDL_C) next_byte <= ram.ram_readdata;
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == 3'd0) begin
              bit_idx  <= 3'd7;
              byte_idx <= byte_idx + BW'(1);
              shift_q  <= next_byte;
            end else begin
              bit_idx <= bit_idx - 3'd1;
              shift_q <= {shift_q[6:0], 1'b0};
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        LATCH: begin
          if (cyc == TLATCH_END) cyc <= '0;
          else                   cyc <= cyc + CW'(1);
        end
        default: cyc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_led_streamer.sv
// tb/tb_ram_led_streamer.sv - self-checking bench for ram_led_streamer
module tb_ram_led_streamer;
  localparam int TB_TBIT = 63;
  localparam int TB_T1H  = 40;
  localparam int TB_T0H  = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start [3];
  logic led [3];
  logic busy [3];
  logic fd [3];
  logic cs [3];
  logic [12:0] addr [3];
  logic [7:0] mem [3][0:31];
  logic [7:0] q1 [3];
  logic [7:0] q2_c;
  logic [7:0] pat_a [3];
  logic [7:0] pat_c [3];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;

  int rises [3][$];
  int highs [3][$];
  int cs_t [3][$];
  int cs_a [3][$];
  int fd_t [3][$];
  int bf_t [3][$];
  int rise_at [3];
  logic led_p [3];
  logic busy_p [3];

  always #5 clk = ~clk;

  ram_led_streamer_if #(.ADDR_W(13)) bus_a ();
  ram_led_streamer_if #(.ADDR_W(13)) bus_b ();
  ram_led_streamer_if #(.ADDR_W(13)) bus_c ();

  ram_led_streamer #(.NUM_LEDS(1)) dut_a (
    .clk_clk(clk), .reset_reset_n(reset_n), .start(start[0]), .ram(bus_a),
    .led_dout(led[0]), .busy(busy[0]), .frame_done(fd[0])
  );
  ram_led_streamer #(.NUM_LEDS(2), .BASE_ADDR(16), .TLATCH(200)) dut_b (
    .clk_clk(clk), .reset_reset_n(reset_n), .start(start[1]), .ram(bus_b),
    .led_dout(led[1]), .busy(busy[1]), .frame_done(fd[1])
  );
  ram_led_streamer #(.NUM_LEDS(1), .RD_LATENCY(2), .TLATCH(200)) dut_c (
    .clk_clk(clk), .reset_reset_n(reset_n), .start(start[2]), .ram(bus_c),
    .led_dout(led[2]), .busy(busy[2]), .frame_done(fd[2])
  );

  assign cs[0] = bus_a.ram_chipselect;
  assign cs[1] = bus_b.ram_chipselect;
  assign cs[2] = bus_c.ram_chipselect;
  assign addr[0] = bus_a.ram_address;
  assign addr[1] = bus_b.ram_address;
  assign addr[2] = bus_c.ram_address;
  assign bus_a.ram_readdata = q1[0];
  assign bus_b.ram_readdata = q1[1];
  assign bus_c.ram_readdata = q2_c;

  // RAM models: latency 1 for a/b, latency 2 for c
  always @(posedge clk) begin
    if (bus_a.ram_chipselect) q1[0] <= mem[0][bus_a.ram_address[4:0]];
    if (bus_b.ram_chipselect) q1[1] <= mem[1][bus_b.ram_address[4:0]];
    if (bus_c.ram_chipselect) q1[2] <= mem[2][bus_c.ram_address[4:0]];
    q2_c <= q1[2];
    ncyc <= ncyc + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (led[i] && !led_p[i]) begin rises[i].push_back(ncyc); rise_at[i] = ncyc; end
      if (!led[i] && led_p[i]) highs[i].push_back(ncyc - rise_at[i]);
      if (cs[i]) begin cs_t[i].push_back(ncyc); cs_a[i].push_back(int'(addr[i])); end
      if (fd[i]) fd_t[i].push_back(ncyc);
      if (!busy[i] && busy_p[i]) bf_t[i].push_back(ncyc);
      led_p[i] = led[i];
      busy_p[i] = busy[i];
    end
  end

  task automatic clear_mon(input int i);
    rises[i].delete(); highs[i].delete(); cs_t[i].delete();
    cs_a[i].delete(); fd_t[i].delete(); bf_t[i].delete();
  endtask

  task automatic pulse_start(input int i, output int s);
    @(negedge clk); start[i] = 1'b1; s = ncyc;
    @(negedge clk); start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int k = 0;
    while (busy[i] && k < budget) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL wait_idle_%0d: busy=%b after %0d cycles, required 0", i, busy[i], budget); end
  endtask

  function automatic int exp_high(input logic [7:0] b, input int bit_from_msb);
    logic [7:0] v;
    v = b;
    return v[7 - bit_from_msb] ? TB_T1H : TB_T0H;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (addr[0] !== 13'd0) begin errors++; $display("FAIL reset_addr_a: got %0d, required 0", addr[0]); end
    checks++; if (addr[1] !== 13'd16) begin errors++; $display("FAIL reset_addr_b: got %0d, required 16", addr[1]); end
    checks++; if (cs[0] !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b, required 0", cs[0]); end
    checks++; if (bus_a.ram_clken !== 1'b1) begin errors++; $display("FAIL reset_clken: got %b, required 1", bus_a.ram_clken); end
    checks++; if (bus_a.ram_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b, required 0", bus_a.ram_write); end
    checks++; if (bus_a.ram_writedata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h, required 00", bus_a.ram_writedata); end
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL reset_led: got %b, required 0", led[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy[0]); end
    checks++; if (fd[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, required 0", fd[0]); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy[0] !== 1'b0 || cs[0] !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b cs=%b, required 0 0", busy[0], cs[0]); end
  endtask

  task automatic test_single_frame();
    int s;
    int exp_cs [3];
    clear_mon(0);
    pulse_start(0, s);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL frame_busy_rise: got %b, required 1", busy[0]); end
    wait_idle(0, 6000);
    checks++; if (rises[0].size() != 24) begin errors++; $display("FAIL frame_rise_count: got %0d, required 24", rises[0].size()); end
    for (int j = 0; j < 24 && j < rises[0].size(); j++) begin
      checks++; if (rises[0][j] != s + 3 + TB_TBIT * j) begin errors++; $display("FAIL frame_rise_%0d: got %0d, required %0d", j, rises[0][j] - s, 3 + TB_TBIT * j); end
    end
    for (int j = 0; j < 24 && j < highs[0].size(); j++) begin
      checks++; if (highs[0][j] != exp_high(pat_a[j / 8], j % 8)) begin errors++; $display("FAIL frame_high_%0d: got %0d, required %0d", j, highs[0][j], exp_high(pat_a[j / 8], j % 8)); end
    end
    checks++; if (fd_t[0].size() != 1 || fd_t[0][0] != s + 4514) begin errors++; $display("FAIL frame_done: count %0d first %0d, required 1 at %0d", fd_t[0].size(), (fd_t[0].size() > 0) ? fd_t[0][0] - s : -1, 4514); end
    checks++; if (bf_t[0].size() != 1 || bf_t[0][0] != s + 4515) begin errors++; $display("FAIL frame_busy_fall: count %0d first %0d, required 1 at %0d", bf_t[0].size(), (bf_t[0].size() > 0) ? bf_t[0][0] - s : -1, 4515); end
    exp_cs = '{1, 3, 507};
    checks++; if (cs_t[0].size() != 3) begin errors++; $display("FAIL frame_read_count: got %0d, required 3", cs_t[0].size()); end
    for (int k = 0; k < 3 && k < cs_t[0].size(); k++) begin
      checks++; if (cs_t[0][k] != s + exp_cs[k] || cs_a[0][k] != k) begin errors++; $display("FAIL frame_read_%0d: at %0d addr %0d, required at %0d addr %0d", k, cs_t[0][k] - s, cs_a[0][k], exp_cs[k], k); end
    end
  endtask

  task automatic test_base_addr();
    int s;
    int exp_t;
    clear_mon(1);
    pulse_start(1, s);
    wait_idle(1, 4000);
    checks++; if (cs_t[1].size() != 6) begin errors++; $display("FAIL base_read_count: got %0d, required 6", cs_t[1].size()); end
    for (int k = 0; k < 6 && k < cs_t[1].size(); k++) begin
      exp_t = (k == 0) ? 1 : 3 + 8 * TB_TBIT * (k - 1);
      checks++; if (cs_t[1][k] != s + exp_t || cs_a[1][k] != 16 + k) begin errors++; $display("FAIL base_read_%0d: at %0d addr %0d, required at %0d addr %0d", k, cs_t[1][k] - s, cs_a[1][k], exp_t, 16 + k); end
    end
    checks++; if (rises[1].size() != 48) begin errors++; $display("FAIL base_rise_count: got %0d, required 48", rises[1].size()); end
    checks++; if (rises[1].size() > 0 && rises[1][0] != s + 3) begin errors++; $display("FAIL base_first_rise: got %0d, required 3", rises[1][0] - s); end
    for (int j = 0; j + 1 < rises[1].size(); j++) begin
      checks++; if (rises[1][j + 1] - rises[1][j] != TB_TBIT) begin errors++; $display("FAIL base_period_%0d: got %0d, required %0d", j, rises[1][j + 1] - rises[1][j], TB_TBIT); end
    end
    checks++; if (bf_t[1].size() != 1 || bf_t[1][0] != s + 3227) begin errors++; $display("FAIL base_busy_fall: count %0d, required 1 at 3227", bf_t[1].size()); end
  endtask

  task automatic test_rd_latency2();
    int s;
    int exp_cs [3];
    clear_mon(2);
    pulse_start(2, s);
    wait_idle(2, 3000);
    checks++; if (rises[2].size() != 24) begin errors++; $display("FAIL lat2_rise_count: got %0d, required 24", rises[2].size()); end
    checks++; if (rises[2].size() > 0 && rises[2][0] != s + 4) begin errors++; $display("FAIL lat2_first_rise: got %0d, required 4", rises[2][0] - s); end
    for (int j = 0; j < 24 && j < highs[2].size(); j++) begin
      checks++; if (highs[2][j] != exp_high(pat_c[j / 8], j % 8)) begin errors++; $display("FAIL lat2_high_%0d: got %0d, required %0d", j, highs[2][j], exp_high(pat_c[j / 8], j % 8)); end
    end
    exp_cs = '{1, 4, 508};
    for (int k = 0; k < 3 && k < cs_t[2].size(); k++) begin
      checks++; if (cs_t[2][k] != s + exp_cs[k] || cs_a[2][k] != k) begin errors++; $display("FAIL lat2_read_%0d: at %0d addr %0d, required at %0d addr %0d", k, cs_t[2][k] - s, cs_a[2][k], exp_cs[k], k); end
    end
    checks++; if (bf_t[2].size() != 1 || bf_t[2][0] != s + 1716) begin errors++; $display("FAIL lat2_busy_fall: count %0d, required 1 at 1716", bf_t[2].size()); end
  endtask

  task automatic test_ignore_start();
    int s;
    int d;
    clear_mon(0);
    pulse_start(0, s);
    repeat (700) @(negedge clk);
    pulse_start(0, d);
    while (ncyc < s + 2000) @(negedge clk);
    pulse_start(0, d);
    wait_idle(0, 6000);
    repeat (20) @(negedge clk);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: busy=%b, required 0", busy[0]); end
    checks++; if (fd_t[0].size() != 1) begin errors++; $display("FAIL ignore_frame_done_count: got %0d, required 1", fd_t[0].size()); end
    checks++; if (cs_t[0].size() != 3) begin errors++; $display("FAIL ignore_read_count: got %0d, required 3", cs_t[0].size()); end
    checks++; if (rises[0].size() != 24) begin errors++; $display("FAIL ignore_rise_count: got %0d, required 24", rises[0].size()); end
    checks++; if (bf_t[0].size() != 1 || bf_t[0][0] != s + 4515) begin errors++; $display("FAIL ignore_busy_fall: count %0d, required 1 at 4515", bf_t[0].size()); end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    int s2;
    clear_mon(0);
    pulse_start(0, s);
    while (ncyc < s + 510) @(negedge clk);
    checks++; if (led[0] !== 1'b1) begin errors++; $display("FAIL midreset_pre_led: got %b, required 1", led[0]); end
    reset_n = 1'b0;
    #1;
    checks++; if (led[0] !== 1'b0) begin errors++; $display("FAIL midreset_led: got %b, required 0", led[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy[0]); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon(0);
    repeat (50) @(negedge clk);
    checks++; if (rises[0].size() != 0 || cs_t[0].size() != 0 || busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_quiet: rises %0d reads %0d busy %b, required 0 0 0", rises[0].size(), cs_t[0].size(), busy[0]); end
    pulse_start(0, s2);
    wait_idle(0, 6000);
    checks++; if (cs_t[0].size() != 3 || cs_a[0][0] != 0 || cs_t[0][0] != s2 + 1) begin errors++; $display("FAIL midreset_restart_read: count %0d, required 3 with first at addr 0", cs_t[0].size()); end
    checks++; if (rises[0].size() != 24 || rises[0][0] != s2 + 3) begin errors++; $display("FAIL midreset_restart_rise: count %0d, required 24 starting at 3", rises[0].size()); end
    for (int j = 0; j < 24 && j < highs[0].size(); j++) begin
      checks++; if (highs[0][j] != exp_high(pat_a[j / 8], j % 8)) begin errors++; $display("FAIL midreset_high_%0d: got %0d, required %0d", j, highs[0][j], exp_high(pat_a[j / 8], j % 8)); end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int s2;
    int k;
    clear_mon(0);
    pulse_start(0, s);
    k = 0;
    while (!fd[0] && k < 6000) begin @(negedge clk); k++; end
    checks++; if (fd[0] !== 1'b1) begin errors++; $display("FAIL b2b_first_done: frame_done=%b after %0d cycles, required 1", fd[0], k); end
    @(negedge clk); start[0] = 1'b1; s2 = ncyc;
    @(negedge clk); start[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b, required 1", busy[0]); end
    wait_idle(0, 6000);
    checks++; if (s2 != s + 4515) begin errors++; $display("FAIL b2b_restart_time: got %0d, required 4515", s2 - s); end
    checks++; if (fd_t[0].size() != 2 || fd_t[0][1] != s2 + 4514) begin errors++; $display("FAIL b2b_frame_done: count %0d, required 2 with second at 4514", fd_t[0].size()); end
    checks++; if (rises[0].size() != 48 || rises[0][24] != s2 + 3) begin errors++; $display("FAIL b2b_second_rise: count %0d, required 48 with second frame at 3", rises[0].size()); end
    checks++; if (cs_t[0].size() != 6 || cs_a[0][3] != 0) begin errors++; $display("FAIL b2b_reads: count %0d, required 6 restarting at addr 0", cs_t[0].size()); end
    for (int j = 0; j < 24 && j + 24 < highs[0].size(); j++) begin
      checks++; if (highs[0][j + 24] != exp_high(pat_a[j / 8], j % 8)) begin errors++; $display("FAIL b2b_high_%0d: got %0d, required %0d", j, highs[0][j + 24], exp_high(pat_a[j / 8], j % 8)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; led_p[i] = 1'b0; busy_p[i] = 1'b0; rise_at[i] = 0;
      for (int a = 0; a < 32; a++) mem[i][a] = 8'h00;
    end
    pat_a = '{8'hFF, 8'h00, 8'hA5};
    pat_c = '{8'h80, 8'h01, 8'hC3};
    for (int a = 0; a < 3; a++) begin mem[0][a] = pat_a[a]; mem[2][a] = pat_c[a]; end
    mem[1][16] = 8'h12; mem[1][17] = 8'h34; mem[1][18] = 8'h56;
    mem[1][19] = 8'h78; mem[1][20] = 8'h9A; mem[1][21] = 8'hBC;
    test_reset();
    test_single_frame();
    test_base_addr();
    test_rd_latency2();
    test_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
